tone_bank: RTL and testbench

//  Polyphonic phase-accumulator oscillator bank; parametrised successor to the single-voice test tone.

---
 rtl/tone_bank.sv | 169 ++++++++++++++++
 tb/tb_tone_bank.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_bank.sv
// Polyphonic phase-accumulator oscillator bank.
// One voice is visited per cycle during a mix pass; the mono mix is sent to both channels.
module tone_bank #(
    parameter int VOICES   = 8,
    parameter int PHASE_W  = 24,
    parameter int FCW_W    = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_en,
    input  logic [$clog2(VOICES)-1:0]   i_wr_voice,
    input  logic [FCW_W-1:0]            i_wr_fcw,
    input  logic [1:0]                  i_wr_wave,
    input  logic                        i_wr_gate,
    input  logic                        i_sample_req,
    output logic [2*SAMPLE_W-1:0]       o_sample,
    output logic                        o_valid,
    output logic                        o_busy
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
    localparam logic [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SQ_NEG = ~SQ_POS + SAMPLE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state_q, state_nxt;

    logic [IDX_W-1:0]        idx_q, idx_nxt;
    logic signed [ACC_W-1:0] acc_q, acc_nxt;
    logic                    visit;
    logic                    last_visit;

    logic [FCW_W-1:0]   fcw_q   [VOICES];
    logic [1:0]         wave_q  [VOICES];
    logic               gate_q  [VOICES];
    logic [PHASE_W-1:0] phase_q [VOICES];

    logic [SAMPLE_W-1:0] cur_wave;
    logic [ACC_W-1:0]    cur_ext;
    logic [SAMPLE_W-1:0] mix;

    function automatic logic [SAMPLE_W-1:0] wave_of(
        input logic [1:0]         sel,
        input logic [PHASE_W-1:0] p
    );
        logic [SAMPLE_W-1:0] t;
        logic [SAMPLE_W-1:0] u;
        logic [SAMPLE_W-1:0] r;
        t = p[PHASE_W-1 -: SAMPLE_W];
        u = p[PHASE_W-1] ? ~p[PHASE_W-2 -: SAMPLE_W]
                         :  p[PHASE_W-2 -: SAMPLE_W];
        r = '0;
        unique case (sel)
            2'd0: r = {~t[SAMPLE_W-1], t[SAMPLE_W-2:0]};
            2'd1: r = p[PHASE_W-1] ? SQ_NEG : SQ_POS;
            2'd2: r = {~u[SAMPLE_W-1], u[SAMPLE_W-2:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Waveform of the voice under visit, sign-extended into the accumulator.
    assign cur_wave   = wave_of(wave_q[idx_q], phase_q[idx_q]);
    assign cur_ext    = {{IDX_W{cur_wave[SAMPLE_W-1]}}, cur_wave};
    assign last_visit = (state_q == ACCUM) && (idx_q == LAST_IDX);
    assign mix        = acc_nxt[ACC_W-1:IDX_W];

    // Next-state and mix-pass datapath decode.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        acc_nxt   = acc_q;
        visit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_sample_req) begin
                    acc_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                visit = 1'b1;
                if (gate_q[idx_q]) begin
                    acc_nxt = acc_q + $signed(cur_ext);
                end
                if (idx_q == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state, voice index and mix accumulator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            acc_q   <= acc_nxt;
        end
    end

    // Output sample is captured with the final voice so it is stable during DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sample <= '0;
        end else if (last_visit) begin
            o_sample <= {mix, mix};
        end
    end

    // Voice control registers from the write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                fcw_q[v]  <= '0;
                wave_q[v] <= '0;
                gate_q[v] <= 1'b0;
            end
        end else if (i_wr_en) begin
            fcw_q[i_wr_voice]  <= i_wr_fcw;
            wave_q[i_wr_voice] <= i_wr_wave;
            gate_q[i_wr_voice] <= i_wr_gate;
        end
    end

    // Phase advance on visit; a fresh gate-on restarts the voice at phase 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_q[v] <= '0;
            end
        end else begin
            if (visit) begin
                phase_q[idx_q] <= gate_q[idx_q]
                                ? phase_q[idx_q] + PHASE_W'(fcw_q[idx_q])
                                : '0;
            end
            if (i_wr_en && i_wr_gate && !gate_q[i_wr_voice]) begin
                phase_q[i_wr_voice] <= '0;
            end
        end
    end

    assign o_busy  = (state_q == ACCUM);
    assign o_valid = (state_q == DONE);

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank with four voices.
// Expected samples are hand-derived from the waveform and mix equations.
module tb_tone_bank;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_wr_en;
    logic [1:0]  i_wr_voice;
    logic [15:0] i_wr_fcw;
    logic [1:0]  i_wr_wave;
    logic        i_wr_gate;
    logic        i_sample_req;
    logic [31:0] o_sample;
    logic        o_valid;
    logic        o_busy;

    int n_chk;
    int n_err;

    tone_bank #(
        .VOICES  (4),
        .PHASE_W (24),
        .FCW_W   (16),
        .SAMPLE_W(16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_en     (i_wr_en),
        .i_wr_voice  (i_wr_voice),
        .i_wr_fcw    (i_wr_fcw),
        .i_wr_wave   (i_wr_wave),
        .i_wr_gate   (i_wr_gate),
        .i_sample_req(i_sample_req),
        .o_sample    (o_sample),
        .o_valid     (o_valid),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_wr_en      = 1'b0;
        i_wr_voice   = '0;
        i_wr_fcw     = '0;
        i_wr_wave    = '0;
        i_wr_gate    = 1'b0;
        i_sample_req = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic wr(input logic [1:0] v, input logic [15:0] f,
                      input logic [1:0] w, input logic g);
        i_wr_en    = 1'b1;
        i_wr_voice = v;
        i_wr_fcw   = f;
        i_wr_wave  = w;
        i_wr_gate  = g;
        @(negedge i_clk);
        i_wr_en = 1'b0;
    endtask

    // One mix pass; optional extra request / write at negedge k of the pass.
    task automatic run_pass(input int req2_at, input int wr_at,
                            input logic [1:0] wv, input logic [15:0] wf,
                            input logic [1:0] ww, input logic wg,
                            input logic done_req,
                            output int lat, output int busy_n);
        lat          = 0;
        busy_n       = 0;
        i_sample_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            i_sample_req = (k == req2_at);
            if (k == wr_at) begin
                i_wr_en    = 1'b1;
                i_wr_voice = wv;
                i_wr_fcw   = wf;
                i_wr_wave  = ww;
                i_wr_gate  = wg;
            end else begin
                i_wr_en = 1'b0;
            end
            if (o_busy) busy_n++;
            if (o_valid) begin
                lat = k;
                break;
            end
        end
        i_wr_en      = 1'b0;
        i_sample_req = done_req;
        @(negedge i_clk);
        i_sample_req = 1'b0;
    endtask

    task automatic pass(output int lat);
        int b;
        run_pass(0, 0, 2'd0, 16'h0, 2'd0, 1'b0, 1'b0, lat, b);
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge i_clk);
            if (o_valid) n++;
        end
    endtask

    initial begin
        int lat;
        int busy_n;
        int nv;
        int bad_lat;
        int xbad;
        n_chk = 0;
        n_err = 0;

        // T1 reset and idle pass
        do_reset();
        check("rst_sample", 64'(o_sample), 64'h0);
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_busy", 64'(o_busy), 64'h0);
        run_pass(0, 0, 2'd0, 16'h0, 2'd0, 1'b0, 1'b0, lat, busy_n);
        check("t1_latency", 64'(lat), 64'd5);
        check("t1_busy_cycles", 64'(busy_n), 64'd4);
        check("t1_sample", 64'(o_sample), 64'h0);

        // T2 single saw voice
        do_reset();
        wr(2'd0, 16'h1000, 2'd0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            pass(lat);
            if (i == 1)  check("t2_pass1", 64'(o_sample), 64'hE000E000);
            if (i == 2)  check("t2_pass2", 64'(o_sample), 64'hE004E004);
            if (i == 16) check("t2_pass16", 64'(o_sample), 64'hE03CE03C);
            if (i == 17) check("t2_pass17", 64'(o_sample), 64'hE040E040);
        end

        // T3 square mix and gating
        do_reset();
        for (int v = 0; v < 4; v++) wr(2'(v), 16'h0, 2'd1, 1'b1);
        pass(lat);
        check("t3_sq4", 64'(o_sample), 64'h7FFF7FFF);
        wr(2'd1, 16'h0, 2'd1, 1'b0);
        pass(lat);
        check("t3_sq3", 64'(o_sample), 64'h5FFF5FFF);

        // Triangle on its falling half (phase 0x80FF7F)
        do_reset();
        wr(2'd0, 16'hFFFF, 2'd2, 1'b1);
        for (int i = 0; i < 129; i++) pass(lat);
        pass(lat);
        check("tri_fall", 64'(o_sample), 64'h1F801F80);

        // T4 phase wrap
        do_reset();
        wr(2'd0, 16'hFFFF, 2'd0, 1'b1);
        bad_lat = 0;
        xbad    = 0;
        for (int i = 0; i < 300; i++) begin
            pass(lat);
            if (lat != 5) bad_lat++;
            if ($isunknown(o_sample)) xbad++;
        end
        check("t4_latency_bad", 64'(bad_lat), 64'd0);
        check("t4_x_seen", 64'(xbad), 64'd0);
        pass(lat);
        check("t4_wrap", 64'(o_sample), 64'hEAFFEAFF);

        // T5 request collisions and write on visit cycle
        do_reset();
        wr(2'd2, 16'h1000, 2'd0, 1'b1);
        run_pass(2, 3, 2'd2, 16'h8000, 2'd0, 1'b1, 1'b1, lat, busy_n);
        check("t5_latency", 64'(lat), 64'd5);
        check("t5_passA", 64'(o_sample), 64'hE000E000);
        count_valid(8, nv);
        check("t5_no_extra_valid", 64'(nv), 64'd0);
        pass(lat);
        check("t5_passB", 64'(o_sample), 64'hE004E004);
        pass(lat);
        check("t5_passC", 64'(o_sample), 64'hE024E024);

        // T6 reset in the middle of a pass
        do_reset();
        wr(2'd3, 16'h0, 2'd1, 1'b1);
        pass(lat);
        check("t6_pre", 64'(o_sample), 64'h1FFF1FFF);
        i_sample_req = 1'b1;
        @(negedge i_clk);
        i_sample_req = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("t6_valid", 64'(o_valid), 64'h0);
        check("t6_busy", 64'(o_busy), 64'h0);
        check("t6_sample", 64'(o_sample), 64'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        count_valid(8, nv);
        check("t6_no_valid", 64'(nv), 64'd0);
        pass(lat);
        check("t6_post_lat", 64'(lat), 64'd5);
        check("t6_post_cleared", 64'(o_sample), 64'h0);
        wr(2'd3, 16'h0, 2'd1, 1'b1);
        pass(lat);
        check("t6_post_sample", 64'(o_sample), 64'h1FFF1FFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
